// File: rtl/hci_package.sv
// Shared defaults and types for the HCI TCDM bank responder.
package hci_package;

   localparam int unsigned DEFAULT_DW = 32;
   localparam int unsigned DEFAULT_BW = 8;
   localparam int unsigned DEFAULT_UW = 1;

   typedef enum logic {
      BANK_IDLE  = 1'b0,
      BANK_TS_WB = 1'b1
   } hci_bank_state_t;

   // User ports keep at least one bit so they exist when UW = 0.
   function automatic int unsigned user_w(input int unsigned uw);
      return (uw > 0) ? uw : 1;
   endfunction

endpackage

// File: rtl/hci_tcdm_bank_array.sv
// Single-port bank storage: per-byte write mask, registered read, unreset contents.
module hci_tcdm_bank_array
   import hci_package::*;
#(
   parameter int unsigned AW = 10,
   parameter int unsigned DW = DEFAULT_DW,
   parameter int unsigned BW = DEFAULT_BW,
   parameter int unsigned UW = DEFAULT_UW
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   req_i,
   input  logic                   we_i,
   input  logic [AW-1:0]          addr_i,
   input  logic [DW-1:0]          wdata_i,
   input  logic [user_w(UW)-1:0]  wuser_i,
   input  logic [DW/BW-1:0]       be_i,
   output logic [DW-1:0]          rdata_o,
   output logic [user_w(UW)-1:0]  ruser_o
);

   localparam int unsigned NB    = DW / BW;
   localparam int unsigned DEPTH = 2 ** AW;

   logic          wr_en_c;
   logic          rd_en_c;
   logic [DW-1:0] data_mem [DEPTH];
   logic [DW-1:0] rdata_d;
   logic [DW-1:0] rdata_q;

   assign wr_en_c = req_i & we_i;
   assign rd_en_c = req_i & ~we_i;

   always_ff @(posedge clk_i) begin
      if (wr_en_c) begin
         for (int b = 0; b < int'(NB); b++) begin
            if (be_i[b]) begin
               data_mem[addr_i][b*BW +: BW] <= wdata_i[b*BW +: BW];
            end
         end
      end
   end

   // Read register holds its value until the next read.
   always_comb begin
      rdata_d = rdata_q;
      if (rd_en_c) begin
         rdata_d = data_mem[addr_i];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata_o = rdata_q;

   if (UW > 0) begin : g_user
      logic [UW-1:0] user_mem [DEPTH];
      logic [UW-1:0] ruser_d;
      logic [UW-1:0] ruser_q;

      // User bits ignore the byte mask: any write replaces them.
      always_ff @(posedge clk_i) begin
         if (wr_en_c) begin
            user_mem[addr_i] <= wuser_i;
         end
      end

      always_comb begin
         ruser_d = ruser_q;
         if (rd_en_c) begin
            ruser_d = user_mem[addr_i];
         end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            ruser_q <= '0;
         end else begin
            ruser_q <= ruser_d;
         end
      end

      assign ruser_o = ruser_q;
   end else begin : g_nouser
      logic unused_wuser;
      assign unused_wuser = ^wuser_i;
      assign ruser_o      = '0;
   end

endmodule

// File: rtl/hci_tcdm_bank_responder.sv
// TCDM bank port responder: 1-cycle read/write response plus test-and-set write-back.
module hci_tcdm_bank_responder
   import hci_package::*;
#(
   parameter int unsigned AW = 10,
   parameter int unsigned DW = DEFAULT_DW,
   parameter int unsigned BW = DEFAULT_BW,
   parameter int unsigned UW = DEFAULT_UW,
   parameter int unsigned IW = 20
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   mem_req_i,
   input  logic [AW-1:0]          mem_add_i,
   input  logic                   mem_wen_i,
   input  logic [DW-1:0]          mem_data_i,
   input  logic [user_w(UW)-1:0]  mem_user_i,
   input  logic [DW/BW-1:0]       mem_be_i,
   input  logic [IW-1:0]          mem_id_i,
   input  logic                   mem_ts_set_i,
   output logic                   mem_gnt_o,
   output logic                   mem_r_valid_o,
   output logic [DW-1:0]          mem_r_data_o,
   output logic [user_w(UW)-1:0]  mem_r_user_o,
   output logic [IW-1:0]          mem_r_id_o
);

   localparam int unsigned NB  = DW / BW;
   localparam int unsigned UWE = user_w(UW);

   hci_bank_state_t state_d, state_q;
   logic [AW-1:0]   ts_addr_d, ts_addr_q;
   logic            r_valid_d, r_valid_q;
   logic [IW-1:0]   r_id_d, r_id_q;

   logic            grant_c;
   logic            ts_wb_c;
   logic            arr_req_c;
   logic            arr_we_c;
   logic [AW-1:0]   arr_addr_c;
   logic [DW-1:0]   arr_wdata_c;
   logic [UWE-1:0]  arr_wuser_c;
   logic [NB-1:0]   arr_be_c;

   // Grant in IDLE; a test-and-set read schedules one write-back cycle.
   always_comb begin
      state_d   = state_q;
      ts_addr_d = ts_addr_q;
      mem_gnt_o = 1'b0;
      ts_wb_c   = 1'b0;
      case (state_q)
         BANK_IDLE: begin
            mem_gnt_o = 1'b1;
            if (mem_req_i && mem_wen_i && mem_ts_set_i) begin
               ts_addr_d = mem_add_i;
               state_d   = BANK_TS_WB;
            end
         end
         BANK_TS_WB: begin
            ts_wb_c = 1'b1;
            state_d = BANK_IDLE;
         end
         default: state_d = BANK_IDLE;
      endcase
   end

   assign grant_c = mem_req_i & mem_gnt_o;

   // Array port is shared between the request path and the TS write-back.
   always_comb begin
      arr_req_c   = grant_c;
      arr_we_c    = ~mem_wen_i;
      arr_addr_c  = mem_add_i;
      arr_wdata_c = mem_data_i;
      arr_wuser_c = mem_user_i;
      arr_be_c    = mem_be_i;
      if (ts_wb_c) begin
         arr_req_c   = 1'b1;
         arr_we_c    = 1'b1;
         arr_addr_c  = ts_addr_q;
         arr_wdata_c = '1;
         arr_wuser_c = '0;
         arr_be_c    = '1;
      end
   end

   always_comb begin
      r_valid_d = grant_c;
      r_id_d    = r_id_q;
      if (grant_c) begin
         r_id_d = mem_id_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= BANK_IDLE;
         ts_addr_q <= '0;
         r_valid_q <= 1'b0;
         r_id_q    <= '0;
      end else begin
         state_q   <= state_d;
         ts_addr_q <= ts_addr_d;
         r_valid_q <= r_valid_d;
         r_id_q    <= r_id_d;
      end
   end

   hci_tcdm_bank_array #(
      .AW (AW),
      .DW (DW),
      .BW (BW),
      .UW (UW)
   ) i_array (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req_i   (arr_req_c),
      .we_i    (arr_we_c),
      .addr_i  (arr_addr_c),
      .wdata_i (arr_wdata_c),
      .wuser_i (arr_wuser_c),
      .be_i    (arr_be_c),
      .rdata_o (mem_r_data_o),
      .ruser_o (mem_r_user_o)
   );

   assign mem_r_valid_o = r_valid_q;
   assign mem_r_id_o    = r_id_q;

endmodule

// File: doc/hci_tcdm_bank_responder.md
# hci_tcdm_bank_responder

Memory-side responder for one TCDM bank port of the HCI log interconnect. It accepts word-addressed requests from an interconnect master port, stores data with byte-enable writes, and returns read data, response valid and requester ID one cycle after grant. It implements the interconnect's test-and-set protocol: an atomic read that returns the old word and then writes all-ones. One instance serves each memory port, both in the cluster TCDM model and in interconnect testbenches.

## Interface

Parameters:
- AW, 10, word-address width; the bank depth is 2**AW words.
- DW, hci_package::DEFAULT_DW, data width in bits.
- BW, hci_package::DEFAULT_BW, byte width; the bank has DW/BW byte enables.
- UW, hci_package::DEFAULT_UW, user-bit width, stored alongside data; may be 0.
- IW, 20, request-ID width.

Ports:
- Clocking (already decided): one clock, `clk_i`; reset is asynchronous and active-high, `rst_i`.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- mem_req_i  in  1  request valid.
- mem_add_i  in  AW  word address.
- mem_wen_i  in  1  1 = read, 0 = write.
- mem_data_i  in  DW  write data.
- mem_user_i  in  max(UW,1)  write user bits; ignored when UW=0.
- mem_be_i  in  DW/BW  byte enables.
- mem_id_i  in  IW  requester ID.
- mem_ts_set_i  in  1  marks the read as test-and-set.
- mem_gnt_o  out  1  request accepted this cycle.
- mem_r_valid_o  out  1  response valid.
- mem_r_data_o  out  DW  read data.
- mem_r_user_o  out  max(UW,1)  read user bits; '0 when UW=0.
- mem_r_id_o  out  IW  ID of the request being answered.

## Operation

- FSM states are IDLE and TS_WB.
- IDLE:
  - mem_gnt_o = 1 combinationally.
  - A request is granted when mem_req_i=1.
- Granted write (wen=0):
  - Each byte i with be[i]=1 is updated at the clock edge.
  - User bits are written whenever wen=0, regardless of be.
  - mem_ts_set_i is ignored on writes.
- Granted read (wen=1):
  - The word is captured into the r_data/r_user registers.
- Granted read with ts_set=1:
  - Same capture as a plain read, so the old value is returned.
  - The address is latched and the FSM goes to TS_WB.
- TS_WB (exactly one cycle):
  - mem_gnt_o = 0.
  - The latched word gets all data bits set to 1 and user bits set to 0.
  - Return to IDLE.
- Every granted request, read or write, produces mem_r_valid_o=1 on the next cycle, with mem_r_id_o equal to the granted mem_id_i.
- mem_r_data_o and mem_r_user_o change only after a granted read. They hold their value otherwise, including across writes.
- mem_r_id_o updates on every granted request and holds otherwise.
- Addresses wrap naturally within 2**AW; there is no out-of-range detection.

## Timing

- Read latency is 1: a grant at edge N gives r_valid/r_data valid in cycle N+1. Back-to-back reads sustain one per cycle.
- Write data is visible to a read granted on the following cycle. Same-cycle read/write conflicts cannot occur because there is a single port.
- After a test-and-set, the next request is stalled exactly one cycle. A requester must hold req and its payload while gnt=0.
- A test-and-set followed by a read of the same address returns all-ones.
- Reset values:
  - FSM = IDLE.
  - mem_r_valid_o = 0, mem_r_data_o = '0, mem_r_user_o = '0, mem_r_id_o = '0.
  - mem_gnt_o is 1 once the FSM is in IDLE.
- Storage array contents are not reset and are undefined after power-up.
- Reset asserted while in TS_WB aborts the write-back: the word keeps its old value and the FSM returns to IDLE.
- mem_r_valid_o is never asserted on a cycle with no preceding grant.

## Structure

- hci_package holds:
  - the defaults DEFAULT_DW, DEFAULT_BW, DEFAULT_UW;
  - a new enum hci_bank_state_t {BANK_IDLE, BANK_TS_WB}.
- Sub-module hci_tcdm_bank_array:
  - 2**AW x (UW+DW) flop/latch storage;
  - a single port with per-byte write mask and registered read;
  - no reset on contents.
- The top level contains the FSM, the TS address latch, the ID/valid pipeline and the write-mux that selects between the request path and the TS write-back path.

## Test plan

- Write 0xDEADBEEF with be=4'hF to addr 5, then read addr 5 with id=3 → the cycle after the read grant shows r_valid=1, r_data=0xDEADBEEF, r_id=3.
- Write 0x11223344 with be=4'hF, then write 0xAABBCCDD with be=4'b0101 to the same address, then read → r_data=0x11BB33DD.
- Test-and-set read on addr 7 holding 0 → r_data=0 and gnt=0 for one cycle. A following read of addr 7, held through the stall, returns 0xFFFFFFFF.
- Reads of addr 0..3 every cycle → 4 consecutive r_valid pulses in order with no bubble, and r_id matches each request.
- A write granted with id=9 → r_valid=1, r_id=9 and r_data unchanged from the previous read.
- Assert rst_i during TS_WB → all outputs go to reset values, and a read of the TS address returns its pre-TS value.
